// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: word width, state encoding and
// default reset/interrupt vectors and the memory fill word that halts fetching.
package fetch_unit_pkg;

   localparam int unsigned WORD_W = 16;

   typedef logic [WORD_W-1:0] word_t;

   localparam word_t DEF_RESET_VEC = 16'h0001;
   localparam word_t DEF_IRQ_VEC   = 16'h0000;
   localparam word_t DEF_HALT_WORD = 16'hFFFF;

   localparam logic [1:0] S_BOOT = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HALT = 2'd2;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, pairs each memory word with its address, handles
// stall/redirect/halt. Interrupt entry and IRET are present only when FETCH_IRQ_EN is defined.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter word_t RESET_VEC = DEF_RESET_VEC,
   parameter word_t IRQ_VEC   = DEF_IRQ_VEC,
   parameter word_t HALT_WORD = DEF_HALT_WORD
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] PC,
   input  logic [15:0] INSTR,
   output logic [15:0] IF_INSTR,
   output logic [15:0] IF_PC,
   output logic        IF_VALID,
   input  logic        STALL,
   input  logic        BR_TAKEN,
   input  logic [15:0] BR_TARGET,
   input  logic        IRQ,
   input  logic        IRET,
   output logic        IRQ_ACK,
   output logic        HALTED
);

   logic [1:0]  state_q, state_d;
   logic [15:0] pc_q;
   logic        valid_q, valid_d;
   logic        halted_q, halted_d;
   logic        irq_ack_q, irq_ack_d;
   logic        irq_take;
   logic        halt_irq;
   logic        iret_take;
   logic [15:0] epc;
   logic        is_halt;

`ifdef FETCH_IRQ_EN
   logic [15:0] epc_q, epc_d;
   logic        mask_q, mask_d;

   assign irq_take  = IRQ & ~mask_q & ~STALL & ~BR_TAKEN & ~IRET & valid_q & (state_q == S_RUN);
   assign halt_irq  = IRQ & ~mask_q & ~BR_TAKEN & (state_q == S_HALT);
   assign iret_take = IRET & ~BR_TAKEN & (state_q == S_RUN);
   assign epc       = epc_q;

   // The killed instruction's address is saved so IRET replays it.
   always_comb begin
      epc_d  = epc_q;
      mask_d = mask_q;
      if (irq_take || halt_irq) begin
         epc_d  = pc_q;
         mask_d = 1'b1;
      end else if (iret_take) begin
         mask_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         epc_q  <= 16'h0000;
         mask_q <= 1'b0;
      end else begin
         epc_q  <= epc_d;
         mask_q <= mask_d;
      end
   end
`else
   logic [1:0] unused_irq;

   assign unused_irq = {IRQ, IRET};
   assign irq_take   = 1'b0;
   assign halt_irq   = 1'b0;
   assign iret_take  = 1'b0;
   assign epc        = 16'h0000;
`endif

   assign is_halt = valid_q & (INSTR == HALT_WORD);

   always_comb begin
      PC = RESET_VEC;
      unique case (state_q)
         S_RUN: begin
            if (BR_TAKEN)       PC = BR_TARGET;
            else if (iret_take) PC = epc;
            else if (irq_take)  PC = IRQ_VEC;
            else if (STALL)     PC = pc_q;
            else                PC = pc_q + 16'd1;
         end
         // A resuming redirect fetches its target in the exit cycle.
         S_HALT: begin
            if (BR_TAKEN)      PC = BR_TARGET;
            else if (halt_irq) PC = IRQ_VEC;
            else               PC = pc_q;
         end
         default: PC = RESET_VEC;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      halted_d  = halted_q;
      irq_ack_d = irq_take | halt_irq;
      unique case (state_q)
         S_BOOT: begin
            state_d = S_RUN;
            valid_d = 1'b1;
         end
         S_RUN: begin
            if (is_halt && !BR_TAKEN && !iret_take && !irq_take) begin
               state_d  = S_HALT;
               halted_d = 1'b1;
            end
         end
         S_HALT: begin
            if (BR_TAKEN || halt_irq) begin
               state_d  = S_RUN;
               halted_d = 1'b0;
            end
         end
         default: state_d = S_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_BOOT;
         pc_q      <= RESET_VEC;
         valid_q   <= 1'b0;
         halted_q  <= 1'b0;
         irq_ack_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= PC;
         valid_q   <= valid_d;
         halted_q  <= halted_d;
         irq_ack_q <= irq_ack_d;
      end
   end

   assign IF_INSTR = INSTR;
   assign IF_PC    = pc_q;
   assign IF_VALID = valid_q & (state_q == S_RUN) & ~is_halt & ~BR_TAKEN & ~iret_take
                     & ~irq_take;
   assign IRQ_ACK  = irq_ack_q;
   assign HALTED   = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a registered memory model feeds INSTR, stimulus pushes
// expected {instr, pc} pairs and a negedge monitor pops one per valid output.
module tb_fetch_unit;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [15:0] PC;
   logic [15:0] INSTR;
   logic [15:0] IF_INSTR;
   logic [15:0] IF_PC;
   logic        IF_VALID;
   logic        STALL;
   logic        BR_TAKEN;
   logic [15:0] BR_TARGET;
   logic        IRQ;
   logic        IRET;
   logic        IRQ_ACK;
   logic        HALTED;

   logic [15:0] mem [0:65535];
   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fails  = 0;

   fetch_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .PC        (PC),
      .INSTR     (INSTR),
      .IF_INSTR  (IF_INSTR),
      .IF_PC     (IF_PC),
      .IF_VALID  (IF_VALID),
      .STALL     (STALL),
      .BR_TAKEN  (BR_TAKEN),
      .BR_TARGET (BR_TARGET),
      .IRQ       (IRQ),
      .IRET      (IRET),
      .IRQ_ACK   (IRQ_ACK),
      .HALTED    (HALTED)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) INSTR <= mem[PC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [15:0] instr, input logic [15:0] pc);
      exp_t e;
      e.instr = instr;
      e.pc    = pc;
      sb.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && IF_VALID) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL unexpected_valid: got %h@%h expected none", IF_INSTR, IF_PC);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("if_word", {IF_INSTR, IF_PC}, {e.instr, e.pc});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'hFFFF;
      mem[16'h0000] = 16'h7000;
      mem[16'h0001] = 16'h3000;
      mem[16'h0002] = 16'h0000;
      for (int i = 3; i < 8; i++) mem[i] = 16'h3000 + 16'(i);
      mem[16'h0010] = 16'h6010;
      mem[16'h0011] = 16'h6011;
      mem[16'h0040] = 16'h5040;
      mem[16'h0041] = 16'h5041;
      mem[16'hFFFF] = 16'h7FFF;

      rst_n = 1'b0; STALL = 1'b0; BR_TAKEN = 1'b0; BR_TARGET = 16'h0000;
      IRQ = 1'b0; IRET = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_pc", PC, 16'h0001);
      check("rst_if_pc", IF_PC, 16'h0001);
      check("rst_valid", IF_VALID, 1'b0);
      check("rst_halted", HALTED, 1'b0);
      check("rst_ack", IRQ_ACK, 1'b0);

      // cycle 0: boot bubble
      rst_n = 1'b1;
      #1;
      check("boot_valid", IF_VALID, 1'b0);
      push(16'h3000, 16'h0001);
      push(16'h0000, 16'h0002);
      repeat (4) push(16'h3003, 16'h0003);

      cyc(); check("seq_pc1", PC, 16'h0002);
      cyc(); check("seq_pc2", PC, 16'h0003);
      cyc(); STALL = 1'b1; #1; check("stall_pc_a", PC, 16'h0003);
      cyc(); check("stall_pc_b", PC, 16'h0003); check("stall_if_pc", IF_PC, 16'h0003);
      cyc(); check("stall_pc_c", PC, 16'h0003); check("stall_valid", IF_VALID, 1'b1);
      cyc(); STALL = 1'b0; #1; check("unstall_pc", PC, 16'h0004);

      // cycle 7: branch beats stall, killing 3004@4
      cyc(); STALL = 1'b1; BR_TAKEN = 1'b1; BR_TARGET = 16'h0040; #1;
      check("br_pc", PC, 16'h0040);
      check("br_kill", IF_VALID, 1'b0);
      push(16'h5040, 16'h0040);
      push(16'h5041, 16'h0041);
      cyc(); STALL = 1'b0; BR_TAKEN = 1'b0; #1; check("br_next_pc", PC, 16'h0041);
      cyc();
      cyc(); check("halt_word_valid", IF_VALID, 1'b0); check("halt_not_yet", HALTED, 1'b0);
      cyc(); check("halted", HALTED, 1'b1); check("halt_pc_a", PC, 16'h0043);
      cyc(); check("halt_pc_b", PC, 16'h0043); check("halt_valid", IF_VALID, 1'b0);
      BR_TAKEN = 1'b1; BR_TARGET = 16'h0010; #1; check("resume_pc", PC, 16'h0010);
      push(16'h6010, 16'h0010);
      cyc(); BR_TAKEN = 1'b0; #1;
      check("resume_halted", HALTED, 1'b0); check("resume_next_pc", PC, 16'h0011);

      // cycle 14: branch to FFFF, sequential wrap to 0000
      cyc(); BR_TAKEN = 1'b1; BR_TARGET = 16'hFFFF; #1; check("wrap_br_pc", PC, 16'hFFFF);
      push(16'h7FFF, 16'hFFFF);
      push(16'h7000, 16'h0000);
      push(16'h3000, 16'h0001);
      push(16'h0000, 16'h0002);
      push(16'h3003, 16'h0003);
      push(16'h3004, 16'h0004);
      cyc(); BR_TAKEN = 1'b0; #1; check("wrap_pc", PC, 16'h0000);
      cyc(); check("post_wrap_pc", PC, 16'h0001);
      repeat (4) cyc();

      // cycle 20 done; cycle 21 presents 3005@5
`ifdef FETCH_IRQ_EN
      cyc(); IRQ = 1'b1; #1;
      check("irq_pc", PC, 16'h0000); check("irq_kill", IF_VALID, 1'b0);
      push(16'h7000, 16'h0000);
      push(16'h3005, 16'h0005);
      push(16'h3006, 16'h0006);
      cyc(); check("irq_ack", IRQ_ACK, 1'b1); check("irq_masked_pc", PC, 16'h0001);
      cyc(); IRQ = 1'b0; IRET = 1'b1; #1;
      check("ack_pulse", IRQ_ACK, 1'b0); check("iret_pc", PC, 16'h0005);
      check("iret_kill", IF_VALID, 1'b0);
      cyc(); IRET = 1'b0; #1; check("replay_pc", PC, 16'h0006);
      cyc();
`else
      cyc(); IRQ = 1'b1; IRET = 1'b1; #1;
      check("noirq_pc", PC, 16'h0006); check("noirq_valid", IF_VALID, 1'b1);
      push(16'h3005, 16'h0005);
      push(16'h3006, 16'h0006);
      cyc(); check("noirq_ack", IRQ_ACK, 1'b0);
      IRQ = 1'b0; IRET = 1'b0;
`endif

      // asynchronous reset mid-operation
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_pc", PC, 16'h0001);
      check("async_rst_if_pc", IF_PC, 16'h0001);
      check("async_rst_valid", IF_VALID, 1'b0);
      check("async_rst_halted", HALTED, 1'b0);
      check("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
